// File: rtl/ifft8_stream_pkg.sv
// Shared constants, FSM encoding and butterfly-pair addressing for the 8-point
// inverse add/sub transform.
package ifft8_stream_pkg;
   localparam int N     = 8;
   localparam int LOG2N = 3;

   typedef enum logic [2:0] {LOAD, ST1, ST2, ST3, EMIT} state_t;

   function automatic logic [LOG2N-1:0] stage_stride(input state_t st);
      case (st)
         ST1:     return 3'd4;
         ST2:     return 3'd2;
         ST3:     return 3'd1;
         default: return 3'd4;
      endcase
   endfunction

   // Lower index of butterfly pair j; the partner sits one stride above it.
   function automatic logic [LOG2N-1:0] pair_lo(input state_t st, input logic [1:0] j);
      case (st)
         ST2:     return {j[1], 1'b0, j[0]};
         ST3:     return {j, 1'b0};
         default: return {1'b0, j};
      endcase
   endfunction
endpackage

// File: rtl/ifft8_stream_if.sv
// Bin input stream and sample output stream of ifft8_stream.
interface ifft8_stream_if
   import ifft8_stream_pkg::*;
#(parameter int IN_W = 11);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [IN_W-1:0] out_data;
   logic [LOG2N-1:0]       out_idx;
   logic                   frame_done;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, frame_done
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, frame_done
   );
endinterface

// File: rtl/ifft8_stream_bfly.sv
// Combinational radix-2 add/sub butterfly; wide enough that it never overflows.
module ifft_bfly #(
   parameter int W = 14
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic signed [W-1:0] diff
);
   assign sum  = a + b;
   assign diff = a - b;
endmodule

// File: rtl/ifft8_stream.sv
// 8-point inverse Sylvester-Hadamard transform: load 8 bins, three in-place
// butterfly stages (one per clock), then stream y[n] = floor(sum/8) in order.
module ifft8_stream
   import ifft8_stream_pkg::*;
#(
   parameter int IN_W = 11
) (
   input  logic           c,
   input  logic           r,
   input  logic           e,
   ifft8_stream_if.slave  io
);
   localparam int W = IN_W + LOG2N;

   state_t                state_q, state_d;
   logic [LOG2N-1:0]      cnt_q, cnt_d;
   logic signed [W-1:0]   mem_q [N];
   logic                  wr_in, wr_bf;
   logic [LOG2N-1:0]      lo_idx [N/2];
   logic [LOG2N-1:0]      hi_idx [N/2];
   logic signed [W-1:0]   bf_a [N/2];
   logic signed [W-1:0]   bf_b [N/2];
   logic signed [W-1:0]   bf_s [N/2];
   logic signed [W-1:0]   bf_d [N/2];

   // Arithmetic shift floors toward -inf; the result always fits in IN_W bits.
   function automatic logic signed [IN_W-1:0] scale_out(input logic signed [W-1:0] v);
      logic signed [W-1:0] sh;
      sh = v >>> LOG2N;
      return sh[IN_W-1:0];
   endfunction

   always_comb begin
      for (int j = 0; j < N/2; j++) begin
         lo_idx[j] = pair_lo(state_q, 2'(j));
         hi_idx[j] = lo_idx[j] + stage_stride(state_q);
         bf_a[j]   = mem_q[lo_idx[j]];
         bf_b[j]   = mem_q[hi_idx[j]];
      end
   end

   for (genvar j = 0; j < N/2; j++) begin : g_bfly
      ifft_bfly #(.W(W)) u_bfly (
         .a    (bf_a[j]),
         .b    (bf_b[j]),
         .sum  (bf_s[j]),
         .diff (bf_d[j])
      );
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      wr_in          = 1'b0;
      wr_bf          = 1'b0;
      io.in_ready    = 1'b0;
      io.out_valid   = 1'b0;
      io.frame_done  = 1'b0;
      case (state_q)
         LOAD: begin
            io.in_ready = e & ~r;
            if (io.in_valid && io.in_ready) begin
               wr_in = 1'b1;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'(N-1)) state_d = ST1;
            end
         end
         ST1: begin
            wr_bf = e;
            if (e) state_d = ST2;
         end
         ST2: begin
            wr_bf = e;
            if (e) state_d = ST3;
         end
         ST3: begin
            wr_bf = e;
            if (e) state_d = EMIT;
         end
         EMIT: begin
            io.out_valid = e & ~r;
            if (io.out_valid && io.out_ready) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'(N-1)) begin
                  io.frame_done = 1'b1;
                  state_d       = LOAD;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign io.out_data = scale_out(mem_q[cnt_q]);
   assign io.out_idx  = cnt_q;

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else if (e) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (wr_in) mem_q[cnt_q] <= {{LOG2N{io.in_data[IN_W-1]}}, io.in_data};
         // In-place butterflies: each pair overwrites its own two slots.
         if (wr_bf) begin
            for (int j = 0; j < N/2; j++) begin
               mem_q[lo_idx[j]] <= bf_s[j];
               mem_q[hi_idx[j]] <= bf_d[j];
            end
         end
      end
   end
endmodule

// File: tb/tb_ifft8_stream.sv
// Randomized frame bench for ifft8_stream against a direct Hadamard-sum reference.
module tb_ifft8_stream;
   localparam int IN_W = 11;

   logic c, r, e;
   int   checks   = 0;
   int   failures = 0;

   ifft8_stream_if #(.IN_W(IN_W)) io ();

   ifft8_stream #(.IN_W(IN_W)) dut (
      .c  (c),
      .r  (r),
      .e  (e),
      .io (io.slave)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // y[n] = floor(sum_k (-1)^popcount(n&k) X[k] / 8)
   function automatic void ref_model(input int x[8], output int y[8]);
      for (int n = 0; n < 8; n++) begin
         int s;
         s = 0;
         for (int k = 0; k < 8; k++) begin
            if ($countones(n & k) % 2 == 1) s -= x[k];
            else                            s += x[k];
         end
         y[n] = s >>> 3;
      end
   endfunction

   function automatic int rnd_bin();
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   // Called just after a falling edge; holds reset for one full cycle.
   task automatic do_reset();
      r            = 1'b1;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      #1;
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_in_ready", io.in_ready, 0);
      chk("rst_out_idx", io.out_idx, 0);
      chk("rst_out_data", io.out_data, 0);
      chk("rst_frame_done", io.frame_done, 0);
      @(negedge c);
      r = 1'b0;
   endtask

   task automatic run_frame(input int x[8], input int gap_pct, input int stall_pct,
                            input int exp_lat, input int freeze,
                            input int abort_in, input int abort_out);
      int y[8];
      int idx, guard, k, n, lat;
      logic rdy, ov, ordy, fd, prev_stall;
      logic signed [IN_W-1:0] od, prev_od;
      logic [2:0] oi, prev_oi;

      ref_model(x, y);
      idx   = 0;
      guard = 0;
      while (idx < 8) begin
         @(negedge c);
         if (abort_in == idx) begin
            do_reset();
            return;
         end
         io.in_valid  = ($urandom_range(0, 99) >= gap_pct);
         io.in_data   = IN_W'(x[idx]);
         io.out_ready = 1'($urandom_range(0, 1));
         #1;
         rdy = io.in_ready;
         chk("in_ready_load", rdy, 1);
         chk("out_valid_load", io.out_valid, 0);
         @(posedge c);
         if (io.in_valid && rdy) idx++;
         guard++;
         if (guard > 2000) begin
            chk("rx_bins_timeout", idx, 8);
            return;
         end
      end

      k          = 0;
      n          = 0;
      lat        = -1;
      prev_stall = 1'b0;
      prev_od    = '0;
      prev_oi    = '0;
      while (n < 8 && k < 400) begin
         @(negedge c);
         k++;
         e            = !(freeze > 0 && k >= freeze && k < freeze + 3);
         io.out_ready = ($urandom_range(0, 99) >= stall_pct);
         io.in_valid  = 1'($urandom_range(0, 1));
         io.in_data   = IN_W'(rnd_bin());
         #1;
         ov   = io.out_valid;
         ordy = io.out_ready;
         od   = io.out_data;
         oi   = io.out_idx;
         fd   = io.frame_done;
         chk("in_ready_busy", io.in_ready, 0);
         if (!e) chk("frozen_out_valid", ov, 0);
         if (ov && lat < 0) lat = k;
         if (prev_stall) begin
            chk("stall_valid", ov, 1);
            chk("stall_data", od, prev_od);
            chk("stall_idx", oi, prev_oi);
         end
         if (abort_out >= 0 && n == abort_out && ov) begin
            do_reset();
            e = 1'b1;
            return;
         end
         @(posedge c);
         if (ov && ordy) begin
            chk("out_data", od, y[n]);
            chk("out_idx", oi, n);
            chk("frame_done", fd, (n == 7));
            n++;
         end else begin
            chk("frame_done_idle", fd, 0);
         end
         prev_stall = ov && !ordy;
         prev_od    = od;
         prev_oi    = oi;
      end
      e = 1'b1;
      if (n < 8) chk("rx_samples_timeout", n, 8);
      if (exp_lat >= 0) chk("latency", lat, exp_lat);
   endtask

   initial begin
      int xv[8];
      r            = 1'b1;
      e            = 1'b1;
      io.in_valid  = 1'b0;
      io.in_data   = '0;
      io.out_ready = 1'b0;
      repeat (2) @(negedge c);
      chk("init_in_ready", io.in_ready, 0);
      chk("init_out_valid", io.out_valid, 0);
      chk("init_out_data", io.out_data, 0);
      chk("init_out_idx", io.out_idx, 0);
      chk("init_frame_done", io.frame_done, 0);
      r = 1'b0;

      xv = '{8, 0, 0, 0, 0, 0, 0, 0};
      run_frame(xv, 0, 0, 4, 0, -1, -1);
      xv = '{0, 8, 0, 0, 0, 0, 0, 0};
      run_frame(xv, 0, 0, 4, 0, -1, -1);
      xv = '{8, 8, 8, 8, 8, 8, 8, 8};
      run_frame(xv, 0, 0, -1, 0, -1, -1);
      xv = '{-1, 0, 0, 0, 0, 0, 0, 0};
      run_frame(xv, 0, 0, -1, 0, -1, -1);
      xv = '{1, 0, 0, 0, 0, 0, 0, 0};
      run_frame(xv, 0, 0, -1, 0, -1, -1);
      xv = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
      run_frame(xv, 0, 0, -1, 0, -1, -1);
      xv = '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024};
      run_frame(xv, 0, 0, -1, 0, -1, -1);

      // Same random frame with and without stalls.
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 8; i++) xv[i] = rnd_bin();
         run_frame(xv, 0, 0, 4, 0, -1, -1);
         run_frame(xv, 40, 50, -1, 0, -1, -1);
      end

      // Reset after 5 bins, then an impulse frame.
      for (int i = 0; i < 8; i++) xv[i] = rnd_bin();
      run_frame(xv, 0, 0, -1, 0, 5, -1);
      xv = '{8, 0, 0, 0, 0, 0, 0, 0};
      run_frame(xv, 0, 0, 4, 0, -1, -1);

      // Reset in the middle of output.
      for (int i = 0; i < 8; i++) xv[i] = rnd_bin();
      run_frame(xv, 0, 0, -1, 0, -1, 3);
      xv = '{8, 0, 0, 0, 0, 0, 0, 0};
      run_frame(xv, 0, 0, 4, 0, -1, -1);

      // Enable low for 3 cycles while in ST2.
      for (int i = 0; i < 8; i++) xv[i] = rnd_bin();
      run_frame(xv, 0, 0, 7, 2, -1, -1);

      // Back-to-back random frames.
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) xv[i] = rnd_bin();
         run_frame(xv, 0, 0, 4, 0, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
